// File: rtl/axis_rr_packet_arbiter.sv
// Packet-locked round-robin arbiter: R AXI-Stream sources share one downstream stream.
// The winner owns axis_out until its tlast beat handshakes, then the next source in rotation wins.
module axis_rr_packet_arbiter #(
  parameter int unsigned R      = 4,
  parameter int unsigned N      = 8,
  parameter int unsigned I      = 1,
  parameter int unsigned D      = 1,
  parameter int unsigned U      = 1,
  parameter bit          TAG_ID = 1'b0,
  localparam int unsigned GW    = (R > 1) ? $clog2(R) : 1
) (
  input  logic                      aclk,
  input  logic                      aresetn,

  input  logic [R-1:0]              axis_in_tvalid,
  output logic [R-1:0]              axis_in_tready,
  input  logic [R-1:0][8*N-1:0]     axis_in_tdata,
  input  logic [R-1:0][N-1:0]       axis_in_tkeep,
  input  logic [R-1:0][N-1:0]       axis_in_tstrb,
  input  logic [R-1:0]              axis_in_tlast,
  input  logic [R-1:0][I-1:0]       axis_in_tid,
  input  logic [R-1:0][D-1:0]       axis_in_tdest,
  input  logic [R-1:0][U-1:0]       axis_in_tuser,

  output logic                      axis_out_tvalid,
  input  logic                      axis_out_tready,
  output logic [8*N-1:0]            axis_out_tdata,
  output logic [N-1:0]              axis_out_tkeep,
  output logic [N-1:0]              axis_out_tstrb,
  output logic                      axis_out_tlast,
  output logic [I-1:0]              axis_out_tid,
  output logic [D-1:0]              axis_out_tdest,
  output logic [U-1:0]              axis_out_tuser,

  output logic [GW-1:0]             grant,
  output logic                      busy
);

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] ptr_q, ptr_d;

  logic          found;
  logic [GW-1:0] pick;
  logic [GW:0]   sum;
  logic [GW-1:0] idx;

  // First requester at or after ptr, wrapping modulo R (works for non-power-of-2 R).
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    sum   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < R; k++) begin
      sum = {1'b0, ptr_q} + (GW+1)'(k);
      if (sum >= (GW+1)'(R)) begin
        sum = sum - (GW+1)'(R);
      end
      idx = sum[GW-1:0];
      if (!found && axis_in_tvalid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Payload mux follows the registered grant; only tvalid/tready are gated by state.
  always_comb begin
    axis_out_tdata  = axis_in_tdata[grant_q];
    axis_out_tkeep  = axis_in_tkeep[grant_q];
    axis_out_tstrb  = axis_in_tstrb[grant_q];
    axis_out_tlast  = axis_in_tlast[grant_q];
    axis_out_tdest  = axis_in_tdest[grant_q];
    axis_out_tuser  = axis_in_tuser[grant_q];
    axis_out_tvalid = (state_q == StLock) && axis_in_tvalid[grant_q];
    axis_in_tready  = '0;
    if (state_q == StLock) begin
      axis_in_tready[grant_q] = axis_out_tready;
    end
  end

  if (TAG_ID) begin : g_tag_id
    assign axis_out_tid = I'(grant_q);
  end else begin : g_pass_id
    assign axis_out_tid = axis_in_tid[grant_q];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = pick;
          state_d = StLock;
        end
      end
      StLock: begin
        if (axis_out_tvalid && axis_out_tready && axis_out_tlast) begin
          ptr_d   = (grant_q == GW'(R - 1)) ? '0 : grant_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == StLock);

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Directed bench for axis_rr_packet_arbiter: queued sources, a beat logger, and
// hand-computed expected beat/grant/timing tables; pass-through and tagged-tid instances.
module tb_axis_rr_packet_arbiter;

  localparam int R = 4;
  localparam int N = 8;
  localparam int I = 2;
  localparam int D = 1;
  localparam int U = 1;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic aresetn;

  logic [R-1:0]          in_tvalid, in_tready0, in_tready1, in_tlast;
  logic [R-1:0][8*N-1:0] in_tdata;
  logic [R-1:0][N-1:0]   in_tkeep, in_tstrb;
  logic [R-1:0][I-1:0]   in_tid;
  logic [R-1:0][D-1:0]   in_tdest;
  logic [R-1:0][U-1:0]   in_tuser;
  logic                  out_tready;

  logic           o_tvalid0, o_tlast0, busy0, o_tvalid1, o_tlast1, busy1;
  logic [8*N-1:0] o_tdata0, o_tdata1;
  logic [N-1:0]   o_tkeep0, o_tstrb0, o_tkeep1, o_tstrb1;
  logic [I-1:0]   o_tid0, o_tid1;
  logic [D-1:0]   o_tdest0, o_tdest1;
  logic [U-1:0]   o_tuser0, o_tuser1;
  logic [1:0]     grant0, grant1;

  axis_rr_packet_arbiter #(.R(R), .N(N), .I(I), .D(D), .U(U), .TAG_ID(1'b0)) u_pass (
    .aclk(aclk), .aresetn(aresetn),
    .axis_in_tvalid(in_tvalid), .axis_in_tready(in_tready0), .axis_in_tdata(in_tdata),
    .axis_in_tkeep(in_tkeep), .axis_in_tstrb(in_tstrb), .axis_in_tlast(in_tlast),
    .axis_in_tid(in_tid), .axis_in_tdest(in_tdest), .axis_in_tuser(in_tuser),
    .axis_out_tvalid(o_tvalid0), .axis_out_tready(out_tready), .axis_out_tdata(o_tdata0),
    .axis_out_tkeep(o_tkeep0), .axis_out_tstrb(o_tstrb0), .axis_out_tlast(o_tlast0),
    .axis_out_tid(o_tid0), .axis_out_tdest(o_tdest0), .axis_out_tuser(o_tuser0),
    .grant(grant0), .busy(busy0)
  );

  axis_rr_packet_arbiter #(.R(R), .N(N), .I(I), .D(D), .U(U), .TAG_ID(1'b1)) u_tag (
    .aclk(aclk), .aresetn(aresetn),
    .axis_in_tvalid(in_tvalid), .axis_in_tready(in_tready1), .axis_in_tdata(in_tdata),
    .axis_in_tkeep(in_tkeep), .axis_in_tstrb(in_tstrb), .axis_in_tlast(in_tlast),
    .axis_in_tid(in_tid), .axis_in_tdest(in_tdest), .axis_in_tuser(in_tuser),
    .axis_out_tvalid(o_tvalid1), .axis_out_tready(out_tready), .axis_out_tdata(o_tdata1),
    .axis_out_tkeep(o_tkeep1), .axis_out_tstrb(o_tstrb1), .axis_out_tlast(o_tlast1),
    .axis_out_tid(o_tid1), .axis_out_tdest(o_tdest1), .axis_out_tuser(o_tuser1),
    .grant(grant1), .busy(busy1)
  );

  // Source queues: one byte of payload per beat, popped on handshake.
  logic [7:0]   src_d [R][32];
  logic         src_l [R][32];
  int           src_head [R];
  int           src_tail [R];
  logic [R-1:0] src_en;
  logic         force_v;
  logic [R-1:0] pend;

  always_comb begin
    for (int k = 0; k < R; k++) begin
      in_tvalid[k] = force_v | (src_en[k] && (src_head[k] != src_tail[k]));
      in_tdata[k]  = {56'd0, src_d[k][src_head[k] % 32]};
      in_tlast[k]  = src_l[k][src_head[k] % 32];
      in_tkeep[k]  = 8'hff;
      in_tstrb[k]  = 8'(1 << k);
      in_tid[k]    = 2'(k + 1);
      in_tuser[k]  = 1'(k);
      in_tdest[k]  = 1'(k >> 1);
    end
  end

  // Handshakes are sampled at negedge (inputs only change just after posedge).
  int         cyc = 0;
  int         log_n = 0;
  logic [1:0] log_g [64];
  logic [1:0] log_g1 [64];
  logic [7:0] log_d [64];
  logic [7:0] log_d1 [64];
  logic       log_l [64];
  logic [1:0] log_t0 [64];
  logic [1:0] log_t1 [64];
  logic [7:0] log_s [64];
  logic [1:0] log_ud [64];
  int         log_c [64];

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < R; k++) begin
      if (pend[k]) src_head[k] <= src_head[k] + 1;
    end
  end

  always @(negedge aclk) begin
    pend <= in_tvalid & in_tready0;
    if (aresetn && o_tvalid0 && out_tready && log_n < 64) begin
      log_g[log_n]  <= grant0;
      log_g1[log_n] <= grant1;
      log_d[log_n]  <= o_tdata0[7:0];
      log_d1[log_n] <= o_tdata1[7:0];
      log_l[log_n]  <= o_tlast0;
      log_t0[log_n] <= o_tid0;
      log_t1[log_n] <= o_tid1;
      log_s[log_n]  <= o_tstrb0;
      log_ud[log_n] <= {o_tuser0, o_tdest0};
      log_c[log_n]  <= cyc;
      log_n         <= log_n + 1;
    end
  end

  int n_checks = 0;
  int n_fail = 0;
  int rd = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l);
    src_d[k][src_tail[k] % 32] = d;
    src_l[k][src_tail[k] % 32] = l;
    src_tail[k]++;
  endtask

  task automatic expect_beat(input int g, input int d, input logic l);
    int budget = 0;
    while (log_n <= rd && budget < 60) begin
      tick();
      budget++;
    end
    if (log_n <= rd) begin
      check_eq("beat_timeout", 64'(log_n), 64'(rd + 1));
    end else begin
      check_eq("beat_grant", 64'(log_g[rd]), 64'(g));
      check_eq("beat_grant_tag", 64'(log_g1[rd]), 64'(g));
      check_eq("beat_data", 64'(log_d[rd]), 64'(d));
      check_eq("beat_data_tag", 64'(log_d1[rd]), 64'(d));
      check_eq("beat_last", 64'(log_l[rd]), 64'(l));
      check_eq("beat_tid_pass", 64'(log_t0[rd]), 64'((g + 1) % 4));
      check_eq("beat_tid_tag", 64'(log_t1[rd]), 64'(g));
      check_eq("beat_strb", 64'(log_s[rd]), 64'(1 << g));
      check_eq("beat_user_dest", 64'(log_ud[rd]), 64'({g[0], g[1]}));
      rd++;
    end
  endtask

  int pat [7]  = '{1, 0, 1, 0, 1, 0, 1};
  int expd [7] = '{'ha0, 'ha1, 'ha1, 'ha2, 'ha2, 'ha3, 'ha3};
  int first;

  initial begin
    aresetn    = 1'b0;
    force_v    = 1'b1;
    src_en     = '1;
    out_tready = 1'b1;
    for (int k = 0; k < R; k++) begin
      for (int i = 0; i < 32; i++) begin
        src_d[k][i] = 8'h00;
        src_l[k][i] = 1'b0;
      end
    end

    // Reset with every source valid: outputs quiet before any clock edge.
    #2;
    check_eq("rst_tvalid", 64'(o_tvalid0), 64'd0);
    check_eq("rst_tvalid_tag", 64'(o_tvalid1), 64'd0);
    check_eq("rst_tready", 64'(in_tready0), 64'd0);
    check_eq("rst_grant", 64'(grant0), 64'd0);
    check_eq("rst_busy", 64'(busy0), 64'd0);
    tick();
    tick();
    @(negedge aclk);
    check_eq("rst_hold_tvalid", 64'(o_tvalid0), 64'd0);
    check_eq("rst_hold_busy", 64'(busy0), 64'd0);
    force_v = 1'b0;
    tick();
    aresetn = 1'b1;

    // Single 3-beat packet from source 2.
    push(2, 8'h11, 1'b0);
    push(2, 8'h22, 1'b0);
    push(2, 8'h33, 1'b1);
    @(negedge aclk);
    check_eq("t2_idle_tvalid", 64'(o_tvalid0), 64'd0);
    check_eq("t2_idle_busy", 64'(busy0), 64'd0);
    tick();
    @(negedge aclk);
    check_eq("t2_tvalid", 64'(o_tvalid0), 64'd1);
    check_eq("t2_data", o_tdata0, 64'h11);
    check_eq("t2_grant", 64'(grant0), 64'd2);
    check_eq("t2_busy", 64'(busy0), 64'd1);
    check_eq("t2_tready", 64'(in_tready0), 64'b0100);
    expect_beat(2, 'h11, 1'b0);
    expect_beat(2, 'h22, 1'b0);
    expect_beat(2, 'h33, 1'b1);
    @(negedge aclk);
    check_eq("t2_release_busy", 64'(busy0), 64'd0);
    check_eq("t2_release_grant", 64'(grant0), 64'd2);

    // All four sources, two 2-beat packets each, from ptr=0: rotation with one bubble.
    tick();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    for (int k = 0; k < R; k++) begin
      for (int p = 0; p < 2; p++) begin
        for (int b = 0; b < 2; b++) push(k, 8'(k * 16 + p * 2 + b), b == 1);
      end
    end
    first = rd;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < R; k++) begin
        for (int b = 0; b < 2; b++) begin
          expect_beat(k, k * 16 + p * 2 + b, b == 1);
          if (rd > first) begin
            check_eq("t3_spacing", 64'(log_c[rd-1] - log_c[first]), 64'(3 * (p * 4 + k) + b));
          end
        end
      end
    end

    // Backpressure on source 1's packet while source 2 waits.
    tick();
    tick();
    push(1, 8'ha0, 1'b0);
    push(1, 8'ha1, 1'b0);
    push(1, 8'ha2, 1'b0);
    push(1, 8'ha3, 1'b1);
    push(2, 8'hb0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick();
      out_tready = (pat[i] != 0);
      @(negedge aclk);
      check_eq("t4_data", o_tdata0, 64'(expd[i]));
      check_eq("t4_tvalid", 64'(o_tvalid0), 64'd1);
      check_eq("t4_tready", 64'(in_tready0), (pat[i] != 0) ? 64'b0010 : 64'b0000);
    end
    tick();
    out_tready = 1'b1;
    expect_beat(1, 'ha0, 1'b0);
    expect_beat(1, 'ha1, 1'b0);
    expect_beat(1, 'ha2, 1'b0);
    expect_beat(1, 'ha3, 1'b1);
    expect_beat(2, 'hb0, 1'b1);

    // Granted source 3 stalls 5 cycles mid-packet while source 0 requests.
    tick();
    tick();
    push(3, 8'hc0, 1'b0);
    push(3, 8'hc1, 1'b0);
    push(3, 8'hc2, 1'b0);
    push(3, 8'hc3, 1'b1);
    push(0, 8'hd0, 1'b1);
    tick();
    tick();
    tick();
    src_en[3] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check_eq("t5_grant", 64'(grant0), 64'd3);
      check_eq("t5_busy", 64'(busy0), 64'd1);
      check_eq("t5_tvalid", 64'(o_tvalid0), 64'd0);
      check_eq("t5_tready", 64'(in_tready0), 64'b1000);
      check_eq("t5_tready_tag", 64'(in_tready1), 64'b1000);
      tick();
    end
    src_en[3] = 1'b1;
    expect_beat(3, 'hc0, 1'b0);
    expect_beat(3, 'hc1, 1'b0);
    expect_beat(3, 'hc2, 1'b0);
    expect_beat(3, 'hc3, 1'b1);
    expect_beat(0, 'hd0, 1'b1);

    // Tagged tid from source 3 (own tid 0), then async reset mid-packet.
    tick();
    tick();
    push(3, 8'he0, 1'b0);
    push(3, 8'he1, 1'b0);
    push(3, 8'he2, 1'b1);
    tick();
    @(negedge aclk);
    check_eq("t6_tid_tag", 64'(o_tid1), 64'd3);
    check_eq("t6_tid_pass", 64'(o_tid0), 64'd0);
    tick();
    #1;
    aresetn = 1'b0;
    #1;
    check_eq("t6_rst_tvalid", 64'(o_tvalid0), 64'd0);
    check_eq("t6_rst_tvalid_tag", 64'(o_tvalid1), 64'd0);
    check_eq("t6_rst_busy", 64'(busy0), 64'd0);
    check_eq("t6_rst_grant", 64'(grant0), 64'd0);
    check_eq("t6_rst_tready", 64'(in_tready0), 64'd0);
    tick();
    aresetn = 1'b1;
    expect_beat(3, 'he0, 1'b0);
    expect_beat(3, 'he1, 1'b0);
    expect_beat(3, 'he2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
